param_stack: RTL and testbench

Parametrised LIFO stack, next generation of the processor's return/data stack. Generalises width and depth, adds replace-top, an indexed peek port, occupancy/full/empty status, and sticky overflow/underflow error flags. An overflow policy parameter selects reject-on-full or drop-oldest. Instantiated by the core for the data stack and the return stack; the core decodes stackOP and drives op/w.

---
 rtl/stack_pkg.sv | 9 +
 rtl/stack_read_mux.sv | 24 ++
 rtl/param_stack.sv | 131 +++++++++++++
 tb/tb_param_stack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - stack operation encoding shared with the core's stack-op decoder
package stack_pkg;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_REPLACE = 2'd2;
    localparam logic [1:0] OP_POP     = 2'd3;

endpackage

// File: rtl/stack_read_mux.sv
// rtl/stack_read_mux.sv - masked read of stack entry idx (0 = top) from the circular buffer
module stack_read_mux #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic [AW-1:0]               tp,
    input  logic [AW:0]                 count,
    input  logic [AW-1:0]               idx,
    output logic [WIDTH-1:0]            data
);

    logic [AW-1:0] slot;
    logic          occupied;

    // Unoccupied entries read as zero so stale memory never leaks out.
    always_comb begin
        slot     = tp - idx;
        occupied = ({1'b0, idx} < count);
        data     = occupied ? mem[slot] : '0;
    end

endmodule

// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised LIFO stack on a circular buffer, falling-edge updated
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 64,
    parameter int DROP_OLDEST = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] w,
    input  logic [AW-1:0]    peek_idx,
    input  logic             err_clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] peek,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ONE       = AW'(1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               tp;
    logic [AW-1:0]               tp_nxt;
    logic [AW:0]                 count_nxt;
    logic [AW-1:0]               wr_addr;
    logic                        wr_en;
    logic                        ovf_set;
    logic                        unf_set;

    assign empty = (count == '0);
    assign full  = (count == COUNT_MAX);

    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_addr   = tp;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    tp_nxt    = tp + ONE;
                    count_nxt = count + 1'b1;
                    wr_en     = 1'b1;
                    wr_addr   = tp + ONE;
                end else begin
                    ovf_set = 1'b1;
                    // When full, the slot after top holds the oldest entry.
                    if (DROP_OLDEST != 0) begin
                        tp_nxt  = tp + ONE;
                        wr_en   = 1'b1;
                        wr_addr = tp + ONE;
                    end
                end
            end
            OP_REPLACE: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = tp;
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    tp_nxt    = tp - ONE;
                    count_nxt = count - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            tp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            tp    <= tp_nxt;
            count <= count_nxt;
            ovf   <= ovf_set | (ovf & ~err_clr);
            unf   <= unf_set | (unf & ~err_clr);
        end
    end

    // Memory is not reset; count masks stale contents on every read.
    always_ff @(negedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= w;
        end
    end

    stack_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_a (
        .mem   (mem),
        .tp    (tp),
        .count (count),
        .idx   ('0),
        .data  (a)
    );

    stack_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_b (
        .mem   (mem),
        .tp    (tp),
        .count (count),
        .idx   (ONE),
        .data  (b)
    );

    stack_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_peek (
        .mem   (mem),
        .tp    (tp),
        .count (count),
        .idx   (peek_idx),
        .data  (peek)
    );

endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - bench for param_stack: drop-oldest and reject instances against a queue model
module tb_param_stack;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk;
    logic             reset;
    logic [1:0]       op;
    logic [WIDTH-1:0] w;
    logic [AW-1:0]    peek_idx;
    logic             err_clr;

    logic [WIDTH-1:0] a_d, b_d, peek_d, a_r, b_r, peek_r;
    logic [AW:0]      count_d, count_r;
    logic             empty_d, full_d, ovf_d, unf_d;
    logic             empty_r, full_r, ovf_r, unf_r;

    int errors = 0;
    int checks = 0;

    // Index 0 models DROP_OLDEST=1, index 1 models DROP_OLDEST=0; front of queue is top.
    int q [2][$];
    bit m_ovf [2];
    bit m_unf [2];

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_OLDEST(1)) u_drop (
        .clk(clk), .reset(reset), .op(op), .w(w), .peek_idx(peek_idx), .err_clr(err_clr),
        .a(a_d), .b(b_d), .peek(peek_d), .count(count_d),
        .empty(empty_d), .full(full_d), .ovf(ovf_d), .unf(unf_d)
    );

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_OLDEST(0)) u_rej (
        .clk(clk), .reset(reset), .op(op), .w(w), .peek_idx(peek_idx), .err_clr(err_clr),
        .a(a_r), .b(b_r), .peek(peek_r), .count(count_r),
        .empty(empty_r), .full(full_r), .ovf(ovf_r), .unf(unf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ent(int k, int i);
        return (i < q[k].size()) ? q[k][i] : 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_apply(input logic [1:0] o, input int d, input bit clr, input bit rst);
        for (int k = 0; k < 2; k++) begin
            bit so = 0;
            bit su = 0;
            if (rst) begin
                q[k].delete();
                m_ovf[k] = 0;
                m_unf[k] = 0;
            end else begin
                if (o == OP_PUSH) begin
                    if (q[k].size() < DEPTH) q[k].push_front(d);
                    else begin
                        so = 1;
                        if (k == 0) begin
                            void'(q[k].pop_back());
                            q[k].push_front(d);
                        end
                    end
                end else if (o == OP_REPLACE) begin
                    if (q[k].size() == 0) su = 1;
                    else q[k][0] = d;
                end else if (o == OP_POP) begin
                    if (q[k].size() == 0) su = 1;
                    else void'(q[k].pop_front());
                end
                if (so) m_ovf[k] = 1; else if (clr) m_ovf[k] = 0;
                if (su) m_unf[k] = 1; else if (clr) m_unf[k] = 0;
            end
        end
    endtask

    // Inputs change after the falling edge settles; outputs are compared 1 ns after it.
    task automatic cyc(input logic [1:0] o, input int d, input bit clr, input bit rst);
        op = o; w = d[WIDTH-1:0]; err_clr = clr; reset = rst;
        @(negedge clk);
        #1;
        op = OP_NOP; err_clr = 1'b0; reset = 1'b0;
        model_apply(o, d, clr, rst);
    endtask

    task automatic check_model(input string tag);
        int pi;
        pi = int'(peek_idx);
        chk({tag, " drop.a"},     int'(a_d),     ent(0, 0));
        chk({tag, " drop.b"},     int'(b_d),     ent(0, 1));
        chk({tag, " drop.peek"},  int'(peek_d),  ent(0, pi));
        chk({tag, " drop.count"}, int'(count_d), q[0].size());
        chk({tag, " drop.empty"}, int'(empty_d), int'(q[0].size() == 0));
        chk({tag, " drop.full"},  int'(full_d),  int'(q[0].size() == DEPTH));
        chk({tag, " drop.ovf"},   int'(ovf_d),   int'(m_ovf[0]));
        chk({tag, " drop.unf"},   int'(unf_d),   int'(m_unf[0]));
        chk({tag, " rej.a"},      int'(a_r),     ent(1, 0));
        chk({tag, " rej.b"},      int'(b_r),     ent(1, 1));
        chk({tag, " rej.peek"},   int'(peek_r),  ent(1, pi));
        chk({tag, " rej.count"},  int'(count_r), q[1].size());
        chk({tag, " rej.empty"},  int'(empty_r), int'(q[1].size() == 0));
        chk({tag, " rej.full"},   int'(full_r),  int'(q[1].size() == DEPTH));
        chk({tag, " rej.ovf"},    int'(ovf_r),   int'(m_ovf[1]));
        chk({tag, " rej.unf"},    int'(unf_r),   int'(m_unf[1]));
    endtask

    initial begin
        int npush;
        reset = 1'b1; op = OP_NOP; w = '0; peek_idx = '0; err_clr = 1'b0;

        cyc(OP_NOP, 0, 0, 1);
        check_model("reset");
        chk("reset.empty", int'(empty_d), 1);
        chk("reset.count", int'(count_d), 0);

        cyc(OP_PUSH, 'h1111, 0, 0);
        cyc(OP_PUSH, 'h2222, 0, 0);
        cyc(OP_PUSH, 'h3333, 0, 0);
        peek_idx = 2'd2;
        #1;
        check_model("push3");
        chk("push3.a", int'(a_d), 'h3333);
        chk("push3.b", int'(b_d), 'h2222);
        chk("push3.peek2", int'(peek_d), 'h1111);
        chk("push3.count", int'(count_d), 3);

        cyc(OP_PUSH, 'h4444, 0, 0);
        cyc(OP_PUSH, 'h5555, 0, 0);
        peek_idx = 2'd3;
        #1;
        check_model("overflow");
        chk("ovf.drop.a", int'(a_d), 'h5555);
        chk("ovf.drop.peek3", int'(peek_d), 'h2222);
        chk("ovf.drop.full", int'(full_d), 1);
        chk("ovf.drop.ovf", int'(ovf_d), 1);
        chk("ovf.rej.a", int'(a_r), 'h4444);
        chk("ovf.rej.ovf", int'(ovf_r), 1);

        cyc(OP_NOP, 0, 0, 1);
        cyc(OP_PUSH, 'h1111, 0, 0);
        cyc(OP_PUSH, 'h2222, 0, 0);
        cyc(OP_PUSH, 'h3333, 0, 0);
        cyc(OP_REPLACE, 'hABCD, 0, 0);
        check_model("replace");
        chk("replace.a", int'(a_d), 'hABCD);
        chk("replace.b", int'(b_d), 'h2222);
        chk("replace.count", int'(count_d), 3);
        for (int i = 0; i < 3; i++) cyc(OP_POP, 0, 0, 0);
        check_model("pop3");
        chk("pop3.empty", int'(empty_d), 1);
        chk("pop3.a", int'(a_d), 0);

        cyc(OP_POP, 0, 0, 0);
        check_model("pop_empty");
        chk("pop_empty.unf", int'(unf_d), 1);
        cyc(OP_REPLACE, 'h9999, 0, 0);
        check_model("replace_empty");
        chk("replace_empty.a", int'(a_d), 0);
        cyc(OP_NOP, 0, 1, 0);
        check_model("err_clr");
        chk("err_clr.unf", int'(unf_d), 0);
        cyc(OP_POP, 0, 1, 0);
        check_model("err_clr_set_wins");
        chk("set_wins.unf", int'(unf_d), 1);

        // Values 1..10 with a pop after every third push, forcing wrap-around.
        npush = 0;
        for (int v = 1; v <= 10; v++) begin
            peek_idx = AW'(v);
            cyc(OP_PUSH, v, 0, 0);
            check_model("wrap.push");
            npush++;
            if (npush % 3 == 0) begin
                cyc(OP_POP, 0, 0, 0);
                check_model("wrap.pop");
            end
        end

        for (int n = 0; n < 300; n++) begin
            logic [1:0] o;
            bit clr;
            o = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 7) == 0);
            peek_idx = AW'($urandom_range(0, 3));
            cyc(o, int'($urandom_range(0, 16'hFFFF)), clr, 0);
            check_model("random");
        end

        cyc(OP_NOP, 0, 1, 1);
        cyc(OP_PUSH, 'h0010, 0, 0);
        cyc(OP_PUSH, 'h0020, 0, 0);
        cyc(OP_PUSH, 'h7777, 0, 1);
        check_model("reset_over_push");
        chk("rst_push.count", int'(count_d), 0);
        chk("rst_push.a", int'(a_d), 0);
        cyc(OP_PUSH, 'h0042, 0, 0);
        check_model("after_reset");
        chk("after_reset.a", int'(a_d), 'h0042);
        chk("after_reset.b", int'(b_d), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
